// File: rtl/spi_text_cmd_ctrl.sv
// Command sequencer between the SPI byte receiver and the VGA text RAM write port.
// Each CS frame is one command byte plus operands; CLEAR fills the whole screen in hardware.
module spi_text_cmd_ctrl #(
  parameter int         COLS       = 80,
  parameter int         ROWS       = 30,
  parameter int         ADDR_W     = 12,
  parameter logic [7:0] CLEAR_CHAR = 8'h20,
  parameter logic [7:0] ATTR_RST   = 8'h07
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [ADDR_W-1:0] cursor_addr,
  output logic [7:0]        attr_reg,
  output logic              busy,
  output logic [7:0]        err_count
);
  localparam int DEPTH = COLS * ROWS;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_CMD     = 4'd1;
  localparam logic [3:0] S_ADDR_HI = 4'd2;
  localparam logic [3:0] S_ADDR_LO = 4'd3;
  localparam logic [3:0] S_DATA    = 4'd4;
  localparam logic [3:0] S_ATTR    = 4'd5;
  localparam logic [3:0] S_CUR_HI  = 4'd6;
  localparam logic [3:0] S_CUR_LO  = 4'd7;
  localparam logic [3:0] S_DRAIN   = 4'd8;
  localparam logic [3:0] S_CLEAR   = 4'd9;

  logic [3:0]        state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d, cur_q, cur_d, addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [7:0]        hi_q, hi_d, attr_q, attr_d, err_q, err_d;
  logic              we_q, we_d, busy_q, busy_d, fopen_q, fopen_d;
  logic              err_inc;
  logic [ADDR_W-1:0] opnd, wptr_nx;
  logic              opnd_ok;

  // Big-endian operand completes with the current byte; only the low ADDR_W bits matter.
  assign opnd    = ADDR_W'({hi_q, rx_byte});
  assign opnd_ok = int'(opnd) < DEPTH;
  assign wptr_nx = (wptr_q == LAST) ? '0 : wptr_q + ADDR_W'(1);

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    cur_d   = cur_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hi_d    = hi_q;
    attr_d  = attr_q;
    we_d    = 1'b0;
    busy_d  = busy_q;
    err_inc = 1'b0;
    fopen_d = frame_start ? 1'b1 : (frame_end ? 1'b0 : fopen_q);

    // A new frame restarts parsing; a byte arriving with it is dropped.
    if (frame_start && state_q != S_CLEAR) begin
      state_d = S_CMD;
    end else begin
      case (state_q)
        S_CMD: if (rx_valid) begin
          case (rx_byte)
            8'h01:   state_d = S_ADDR_HI;
            8'h02:   state_d = S_ATTR;
            8'h03: begin
              state_d = S_CLEAR;
              busy_d  = 1'b1;
              wptr_d  = '0;
              cur_d   = '0;
            end
            8'h04:   state_d = S_CUR_HI;
            default: begin
              state_d = S_DRAIN;
              err_inc = 1'b1;
            end
          endcase
        end
        S_ADDR_HI, S_CUR_HI: if (rx_valid) begin
          hi_d    = rx_byte;
          state_d = (state_q == S_ADDR_HI) ? S_ADDR_LO : S_CUR_LO;
        end
        S_ADDR_LO: if (rx_valid) begin
          wptr_d  = opnd_ok ? opnd : '0;
          err_inc = !opnd_ok;
          state_d = S_DATA;
        end
        S_DATA: if (rx_valid) begin
          we_d    = 1'b1;
          addr_d  = wptr_q;
          wdata_d = {attr_q, rx_byte};
          wptr_d  = wptr_nx;
        end
        S_ATTR: if (rx_valid) begin
          attr_d  = rx_byte;
          state_d = S_DRAIN;
        end
        S_CUR_LO: if (rx_valid) begin
          cur_d   = opnd_ok ? opnd : '0;
          err_inc = !opnd_ok;
          state_d = S_DRAIN;
        end
        S_CLEAR: begin
          we_d    = 1'b1;
          addr_d  = wptr_q;
          wdata_d = {attr_q, CLEAR_CHAR};
          err_inc = rx_valid;
          if (wptr_q == LAST) begin
            busy_d  = 1'b0;
            state_d = fopen_d ? S_DRAIN : S_IDLE;
          end else begin
            wptr_d  = wptr_nx;
          end
        end
        default: ;
      endcase
      // Bytes coincident with frame_end were handled above; unfinished operands just vanish.
      if (frame_end && state_q != S_CLEAR && state_d != S_CLEAR) state_d = S_IDLE;
    end

    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      cur_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      hi_q    <= '0;
      attr_q  <= ATTR_RST;
      err_q   <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      fopen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      cur_q   <= cur_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hi_q    <= hi_d;
      attr_q  <= attr_d;
      err_q   <= err_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      fopen_q <= fopen_d;
    end
  end

  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign cursor_addr = cur_q;
  assign attr_reg    = attr_q;
  assign busy        = busy_q;
  assign err_count   = err_q;
endmodule

// File: tb/tb_spi_text_cmd_ctrl.sv
// Bench for spi_text_cmd_ctrl: whole-frame reference model plus a write monitor/scoreboard.
module tb_spi_text_cmd_ctrl;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 2400;

  logic clk = 1'b0, rst_n = 1'b0, frame_start = 1'b0, frame_end = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic mem_we, busy;
  logic [ADDR_W-1:0] mem_addr, cursor_addr;
  logic [15:0] mem_wdata;
  logic [7:0] attr_reg, err_count;

  int errors = 0, checks = 0;
  logic [ADDR_W+15:0] obs_q[$], exp_q[$];
  logic [7:0] fr[$];
  int m_err = 0, m_cursor = 0;
  logic [7:0] m_attr = 8'h07;

  spi_text_cmd_ctrl dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .frame_end(frame_end),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cursor_addr(cursor_addr), .attr_reg(attr_reg),
    .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (mem_we === 1'b1) obs_q.push_back({mem_addr, mem_wdata});

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic fs_pulse();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
  endtask

  task automatic fe_pulse();
    frame_end = 1'b1; tick(); frame_end = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_byte = b; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
    for (int i = 0; i < gap; i++) tick();
  endtask

  task automatic m_inc_err();
    if (m_err < 255) m_err++;
  endtask

  // Effect of one complete frame, straight from the command rules.
  task automatic model_frame();
    int n, a;
    n = fr.size();
    if (n == 0) return;
    case (fr[0])
      8'h01: if (n >= 3) begin
        a = int'({fr[1], fr[2]}) % (1 << ADDR_W);
        if (a >= DEPTH) begin a = 0; m_inc_err(); end
        for (int i = 3; i < n; i++) begin
          exp_q.push_back({ADDR_W'(a), m_attr, fr[i]});
          a = (a + 1) % DEPTH;
        end
      end
      8'h02: if (n >= 2) m_attr = fr[1];
      8'h03: begin
        m_cursor = 0;
        for (int i = 0; i < DEPTH; i++) exp_q.push_back({ADDR_W'(i), m_attr, 8'h20});
      end
      8'h04: if (n >= 3) begin
        a = int'({fr[1], fr[2]}) % (1 << ADDR_W);
        if (a >= DEPTH) begin a = 0; m_inc_err(); end
        m_cursor = a;
      end
      default: m_inc_err();
    endcase
  endtask

  task automatic send_frame(input int gap);
    fs_pulse();
    foreach (fr[i]) send_byte(fr[i], gap);
    fe_pulse();
    model_frame();
    tick(); tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({mem_we, mem_addr, mem_wdata, cursor_addr, attr_reg, busy, err_count} !==
        {1'b0, 12'd0, 16'd0, 12'd0, 8'h07, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset_values got we=%0b addr=%0d wd=%h cur=%0d attr=%h busy=%0b err=%0d",
               mem_we, mem_addr, mem_wdata, cursor_addr, attr_reg, busy, err_count);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_text();
    fr = {8'h01, 8'h00, 8'h05, 8'h48, 8'h69};
    model_frame();
    fs_pulse();
    send_byte(8'h01, 1); send_byte(8'h00, 1); send_byte(8'h05, 1);
    for (int k = 0; k < 2; k++) begin
      rx_byte = fr[3+k]; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
      checks++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, exp_q[k]}) begin
        errors++;
        $display("FAIL write_latency%0d got we=%0b addr=%0d data=%h want addr=%0d data=%h", k,
                 mem_we, mem_addr, mem_wdata, exp_q[k][27:16], exp_q[k][15:0]);
      end
      tick();
      checks++;
      if (mem_we !== 1'b0) begin
        errors++;
        $display("FAIL write_pulse_width%0d got we=%0b want 0", k, mem_we);
      end
    end
    fe_pulse(); tick();
    checks++;
    if (obs_q.size() != 2) begin
      errors++;
      $display("FAIL hi_write_count got %0d want 2", obs_q.size());
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_wrap();
    fr = {8'h01, 8'h09, 8'h5F, 8'h41, 8'h42}; send_frame(1);
    fr = {8'h01, 8'h0A, 8'h00, 8'h58};        send_frame(0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL wrap_count got %0d want %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL wrap_write%0d got %h want %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (err_count !== 8'(m_err)) begin
      errors++;
      $display("FAIL wrap_err got %0d want %0d", err_count, m_err);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_cursor();
    // last operand byte arrives together with frame_end
    fr = {8'h04, 8'h00, 8'h51};
    fs_pulse(); send_byte(8'h04, 1); send_byte(8'h00, 1);
    rx_byte = 8'h51; rx_valid = 1'b1; frame_end = 1'b1; tick();
    rx_valid = 1'b0; frame_end = 1'b0;
    model_frame(); tick();
    checks++;
    if (cursor_addr !== 12'(m_cursor)) begin
      errors++;
      $display("FAIL cursor_set got %0d want %0d", cursor_addr, m_cursor);
    end
    fr = {8'h04, 8'h00}; send_frame(1);
    checks++;
    if ({cursor_addr, err_count} !== {12'(m_cursor), 8'(m_err)}) begin
      errors++;
      $display("FAIL cursor_truncated got cur=%0d err=%0d want cur=%0d err=%0d",
               cursor_addr, err_count, m_cursor, m_err);
    end
  endtask

  task automatic test_bad_cmd();
    fr = {8'h7F, 8'h11, 8'h22}; send_frame(0);
    checks++;
    if (obs_q.size() != 0 || err_count !== 8'(m_err)) begin
      errors++;
      $display("FAIL bad_cmd got writes=%0d err=%0d want writes=0 err=%0d", obs_q.size(), err_count, m_err);
    end
    fr = {8'h01, 8'h00, 8'h00, 8'h5A}; send_frame(1);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL after_bad_write got n=%0d first=%h want %h", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0] : '0, exp_q[0]);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_clear();
    int cnt, bad;
    fr = {8'h02, 8'h1E}; send_frame(1);
    fr = {8'h03};
    fs_pulse(); send_byte(8'h03, 0); model_frame();
    cnt = 0;
    for (int i = 0; i < 3000 && busy === 1'b1; i++) begin
      cnt++;
      rx_byte = 8'hAA; rx_valid = (i == 10 || i == 20);
      tick();
    end
    rx_valid = 1'b0;
    m_inc_err(); m_inc_err();
    tick(); tick();
    send_byte(8'h55, 1);
    fe_pulse(); tick(); tick();
    checks++;
    if (cnt != DEPTH) begin
      errors++;
      $display("FAIL clear_busy_cycles got %0d want %0d", cnt, DEPTH);
    end
    checks++;
    bad = 0;
    if (obs_q.size() != exp_q.size()) bad = 1;
    else foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) bad++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clear_writes got n=%0d bad=%0d want n=%0d bad=0", obs_q.size(), bad, exp_q.size());
    end
    checks++;
    if ({cursor_addr, err_count, attr_reg} !== {12'(m_cursor), 8'(m_err), m_attr}) begin
      errors++;
      $display("FAIL clear_regs got cur=%0d err=%0d attr=%h want cur=%0d err=%0d attr=%h",
               cursor_addr, err_count, attr_reg, m_cursor, m_err, m_attr);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    int kind, nops;
    logic [7:0] cmd;
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 4);
      cmd  = (kind <= 1) ? 8'h01 : (kind == 2) ? 8'h02 : (kind == 3) ? 8'h04 : 8'($urandom_range(5, 255));
      nops = (cmd == 8'h01) ? $urandom_range(0, 7) : $urandom_range(0, 3);
      fr = {cmd};
      for (int i = 0; i < nops; i++)
        fr.push_back((i == 0 && cmd != 8'h02) ? 8'($urandom_range(0, 10)) : 8'($urandom_range(0, 255)));
      send_frame($urandom_range(0, 1));
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL rand%0d_count got %0d want %0d", f, obs_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          checks++;
          if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL rand%0d_write%0d got %h want %h", f, i, obs_q[i], exp_q[i]);
          end
        end
      end
      checks++;
      if ({cursor_addr, attr_reg, err_count} !== {12'(m_cursor), m_attr, 8'(m_err)}) begin
        errors++;
        $display("FAIL rand%0d_regs got cur=%0d attr=%h err=%0d want cur=%0d attr=%h err=%0d", f,
                 cursor_addr, attr_reg, err_count, m_cursor, m_attr, m_err);
      end
      obs_q.delete(); exp_q.delete();
    end
  endtask

  task automatic test_err_saturate();
    for (int f = 0; f < 260; f++) begin
      fr = {8'hFF};
      fs_pulse(); send_byte(8'hFF, 0); fe_pulse();
      model_frame();
    end
    tick();
    checks++;
    if (err_count !== 8'(m_err) || m_err != 255) begin
      errors++;
      $display("FAIL err_saturate got %0d want %0d", err_count, m_err);
    end
  endtask

  task automatic test_reset_mid_clear();
    int found;
    fs_pulse(); send_byte(8'h03, 0);
    found = 0;
    for (int i = 0; i < 3000 && found == 0; i++) begin
      if (mem_we === 1'b1 && mem_addr == 12'd1000) found = 1;
      else tick();
    end
    checks++;
    if (found == 0) begin
      errors++;
      $display("FAIL clear_reach_1000 got timeout want addr 1000");
    end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    m_attr = 8'h07; m_err = 0; m_cursor = 0;
    checks++;
    if ({busy, mem_we, attr_reg, err_count, cursor_addr} !== {1'b0, 1'b0, m_attr, 8'(m_err), 12'(m_cursor)}) begin
      errors++;
      $display("FAIL mid_clear_reset got busy=%0b we=%0b attr=%h err=%0d cur=%0d want 0 0 07 0 0",
               busy, mem_we, attr_reg, err_count, cursor_addr);
    end
    obs_q.delete();
    send_byte(8'h33, 10);
    checks++;
    if (busy !== 1'b0 || obs_q.size() != 0 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL idle_after_reset got busy=%0b writes=%0d err=%0d want 0 0 0", busy, obs_q.size(), err_count);
    end
  endtask

  initial begin
    test_reset();
    test_write_text();
    test_wrap();
    test_cursor();
    test_bad_cmd();
    test_clear();
    test_random();
    test_err_saturate();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_text_cmd_ctrl.md
Name: spi_text_cmd_ctrl

Overview:
- Command sequencer between the SPI slave byte receiver and the VGA text-mode character RAM.
- Parses each chip-select frame as a command byte plus operands.
- Produces text RAM writes with address auto-increment, attribute and cursor registers, and a hardware screen-clear engine.
- Writes to the character RAM's write port; the VGA scan-out side reads cursor_addr and attr_reg.

Parameters:
COLS, 80, text columns
ROWS, 30, text rows
ADDR_W, 12, RAM address width; must satisfy 2^ADDR_W >= COLS*ROWS
CLEAR_CHAR, 8'h20, character written by CLEAR
ATTR_RST, 8'h07, reset value of attr_reg

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active low
frame_start  in  1  one-cycle pulse on CS falling edge
frame_end  in  1  one-cycle pulse on CS rising edge
rx_valid  in  1  one-cycle pulse, rx_byte holds a complete byte
rx_byte  in  8  received byte, MSB first as assembled by the receiver
mem_we  out  1  text RAM write strobe
mem_addr  out  ADDR_W  text RAM write address
mem_wdata  out  16  {attr, char}
cursor_addr  out  ADDR_W  cursor cell index
attr_reg  out  8  current attribute byte
busy  out  1  high while CLEAR engine runs
err_count  out  8  saturating protocol error counter

Behaviour:
- Clock and reset: one clock, clk; rst_n is synchronous and active low.
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, cursor_addr=0, attr_reg=ATTR_RST, busy=0, err_count=0, state=IDLE, write pointer wptr=0, frame_open=0.
- DEPTH = COLS*ROWS (2400 with defaults).
- States: IDLE, CMD, ADDR_HI, ADDR_LO, DATA, ATTR, CUR_HI, CUR_LO, DRAIN, CLEAR.

Frame tracking:
- frame_start sets frame_open; frame_end clears it.
- frame_start in any state except CLEAR -> CMD; any partially collected operands are discarded.

Command decode (in CMD, on rx_valid):
- 0x01 WRITE_TEXT -> ADDR_HI.
- 0x02 SET_ATTR -> ATTR.
- 0x03 CLEAR -> CLEAR: busy=1 on the next cycle, wptr=0.
- 0x04 SET_CURSOR -> CUR_HI.
- Any other value -> DRAIN, err_count+1.

Operand states:
- ADDR_HI/ADDR_LO collect a 16-bit big-endian address; the low ADDR_W bits are used. After ADDR_LO: if value >= DEPTH then wptr=0 and err_count+1, else wptr=value. Next state DATA.
- DATA: each rx_valid causes, on the following cycle, mem_we=1 for exactly one cycle, mem_addr=wptr, mem_wdata={attr_reg, rx_byte}. wptr then increments, wrapping DEPTH-1 -> 0. Write latency is 1 cycle from rx_valid.
- ATTR: byte -> attr_reg, then DRAIN. Later WRITE_TEXT bytes use the new value.
- CUR_HI/CUR_LO: same range rule as the address; result -> cursor_addr, then DRAIN.
- DRAIN: further bytes ignored without error.
- frame_end in any state except CLEAR -> IDLE. A byte with rx_valid in the same cycle as frame_end is processed first.
- frame_end before an operand completes: operand discarded, no register updated, no error.
- rx_valid in IDLE (no frame) is ignored.

CLEAR engine:
- One write per cycle: mem_we=1, mem_addr=wptr, mem_wdata={attr_reg, CLEAR_CHAR}.
- Runs for DEPTH consecutive cycles, addresses 0..DEPTH-1.
- cursor_addr set to 0 at start.
- During CLEAR: rx_valid bytes dropped with err_count+1 each; frame_start/frame_end only update frame_open.
- After the write to DEPTH-1: busy=0 next cycle; next state DRAIN if frame_open, else IDLE.

Error counter:
- err_count saturates at 255.
- Reset mid-operation (any state, including CLEAR) returns all outputs to reset values on the next edge; the clear is not resumed.

Test Plan:
- Frame {0x01,0x00,0x05,'H','i'} with attr 0x07 -> two writes: addr 5 data 0x0748, addr 6 data 0x0769; each mem_we exactly 1 cycle, 1 cycle after its rx_valid.
- Frame {0x01,0x09,0x5F,'A','B'} (addr 2399) -> writes at 2399 then 0 (wrap). Frame {0x01,0x0A,0x00,'X'} -> write at 0, err_count=1.
- Frame {0x02,0x1E}, then frame {0x03} -> busy high for exactly 2400 cycles; every address 0..2399 written 0x1E20; cursor_addr=0. Two bytes sent during the clear -> err_count+2.
- Frame {0x04,0x00,0x51} -> cursor_addr=81. Frame {0x04,0x00} then frame_end -> cursor unchanged, err_count unchanged.
- Frame {0x7F,0x11,0x22} -> no mem_we, err_count+1. A new frame {0x01,0x00,0x00,'Z'} still writes addr 0 data {attr,0x5A}.
- rst_n low for 1 cycle in the middle of a CLEAR (wptr=1000) -> next cycle busy=0, mem_we=0, attr_reg=0x07, err_count=0, state IDLE.
